// File: rtl/fifo_write_controller.sv
// Write-side pointer, fill and full controller for the asynchronous FIFO (write_clock domain).
// Optional: define WRITE_ALMOST_FULL_EN to add the registered almost_full flag.
module fifo_write_controller #(
  parameter int ADDRESS_WIDTH = 4
`ifdef WRITE_ALMOST_FULL_EN
  , parameter int ALMOST_FULL_THRESHOLD = 2**ADDRESS_WIDTH - 1
`endif
) (
  input  logic                     write_clock,
  input  logic                     write_reset_n,
  input  logic                     write_valid,
  output logic                     write_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH:0]   write_pointer,
  input  logic [ADDRESS_WIDTH:0]   read_pointer,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic                     full,
  output logic                     overflow_error
`ifdef WRITE_ALMOST_FULL_EN
  , output logic                   almost_full
`endif
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
`ifdef WRITE_ALMOST_FULL_EN
  localparam logic [31:0]   AF_TH_FULL = ALMOST_FULL_THRESHOLD;
  localparam logic [PW-1:0] AF_TH      = AF_TH_FULL[PW-1:0];
`endif

  typedef struct packed {
    logic [PW-1:0] ptr;
    logic [PW-1:0] fill;
    logic          full;
    logic          ovf;
`ifdef WRITE_ALMOST_FULL_EN
    logic          afull;
`endif
  } wr_state_t;

  wr_state_t st_q, st_d;

  logic          accept;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] next_fill;

  // Back-pressure comes only from registered flags, so accept never depends on read_pointer.
  assign write_ready   = ~st_q.full & ~st_q.ovf;
  assign accept        = write_valid & write_ready;
  assign write_enable  = accept;
  assign write_address = st_q.ptr[ADDRESS_WIDTH-1:0];

  assign ptr_inc   = st_q.ptr + {{ADDRESS_WIDTH{1'b0}}, accept};
  // Modular difference: the pointer MSB disambiguates full (DEPTH) from empty (0).
  assign next_fill = ptr_inc - read_pointer;

  always_comb begin
    st_d      = st_q;
    st_d.ptr  = ptr_inc;
    st_d.fill = next_fill;
    st_d.full = (next_fill == DEPTH);
    if (next_fill > DEPTH) st_d.ovf = 1'b1;
`ifdef WRITE_ALMOST_FULL_EN
    st_d.afull = (next_fill >= AF_TH);
`endif
  end

  always_ff @(posedge write_clock or negedge write_reset_n) begin
    if (!write_reset_n) st_q <= '0;
    else                st_q <= st_d;
  end

  assign write_pointer  = st_q.ptr;
  assign fill_level     = st_q.fill;
  assign full           = st_q.full;
  assign overflow_error = st_q.ovf;
`ifdef WRITE_ALMOST_FULL_EN
  assign almost_full    = st_q.afull;
`endif

endmodule

// File: tb/tb_fifo_write_controller.sv
// Self-checking bench for fifo_write_controller at ADDRESS_WIDTH=2 (DEPTH=4).
module tb_fifo_write_controller;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_valid;
  logic          write_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [AW:0]   write_pointer;
  logic [AW:0]   read_pointer;
  logic [AW:0]   fill_level;
  logic          full;
  logic          overflow_error;
`ifdef WRITE_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_write_controller #(
    .ADDRESS_WIDTH(AW)
`ifdef WRITE_ALMOST_FULL_EN
    , .ALMOST_FULL_THRESHOLD(3)
`endif
  ) dut (
    .write_clock(clk),
    .write_reset_n(rst_n),
    .write_valid(write_valid),
    .write_ready(write_ready),
    .write_enable(write_enable),
    .write_address(write_address),
    .write_pointer(write_pointer),
    .read_pointer(read_pointer),
    .fill_level(fill_level),
    .full(full),
    .overflow_error(overflow_error)
`ifdef WRITE_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected address.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_enable === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
      else chk("sb_addr", int'(write_address), int'(exp_q.pop_front()));
    end
  end

  // One cycle: drive at posedge+1, check strobe pre-edge, land at next posedge+1.
  task automatic cyc(input logic v, input logic [AW:0] rp, input logic exp_en, input logic [AW-1:0] exp_addr);
    write_valid  = v;
    read_pointer = rp;
    if (exp_en) exp_q.push_back(exp_addr);
    #1;
    chk("write_enable", int'(write_enable), int'(exp_en));
    chk("write_address", int'(write_address), int'(exp_addr));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        v;
    logic [AW:0] rp;
    logic        rdy;
    logic        en;
    logic [AW-1:0] addr;
    logic [AW:0] wp;
    logic [AW:0] fill;
    logic        full;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // fill, saturate, drain by one, simultaneous write+read, wrap
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 1'b1, 2'd0, 3'd1, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 1'b1, 1'b1, 2'd1, 3'd2, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 1'b1, 1'b1, 2'd2, 3'd3, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 1'b1, 1'b1, 2'd3, 3'd4, 3'd4, 1'b1};
    vecs[4]  = '{1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 3'd4, 3'd4, 1'b1};
    vecs[5]  = '{1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 3'd4, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 3'd4, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 1'b1, 1'b1, 2'd0, 3'd5, 3'd4, 1'b1};
    vecs[8]  = '{1'b0, 3'd5, 1'b0, 1'b0, 2'd1, 3'd5, 3'd0, 1'b0};
    vecs[9]  = '{1'b1, 3'd5, 1'b1, 1'b1, 2'd1, 3'd6, 3'd1, 1'b0};
    vecs[10] = '{1'b1, 3'd6, 1'b1, 1'b1, 2'd2, 3'd7, 3'd1, 1'b0};
    vecs[11] = '{1'b0, 3'd4, 1'b1, 1'b0, 2'd3, 3'd7, 3'd3, 1'b0};
    vecs[12] = '{1'b1, 3'd4, 1'b1, 1'b1, 2'd3, 3'd0, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0};

    rst_n = 1'b0; write_valid = 1'b0; read_pointer = '0;
    #12;
    chk("rst_write_pointer", int'(write_pointer), 0);
    chk("rst_fill_level", int'(fill_level), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow_error), 0);
    chk("rst_ready", int'(write_ready), 1);
    chk("rst_enable", int'(write_enable), 0);
`ifdef WRITE_ALMOST_FULL_EN
    chk("rst_almost_full", int'(almost_full), 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      write_valid = vecs[i].v; read_pointer = vecs[i].rp; #0;
      chk($sformatf("v%0d_ready", i), int'(write_ready), int'(vecs[i].rdy));
      cyc(vecs[i].v, vecs[i].rp, vecs[i].en, vecs[i].addr);
      chk($sformatf("v%0d_write_pointer", i), int'(write_pointer), int'(vecs[i].wp));
      chk($sformatf("v%0d_fill_level", i), int'(fill_level), int'(vecs[i].fill));
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].full));
      chk($sformatf("v%0d_overflow", i), int'(overflow_error), 0);
`ifdef WRITE_ALMOST_FULL_EN
      chk($sformatf("v%0d_almost_full", i), int'(almost_full), int'(vecs[i].fill >= 3));
`endif
    end

    // overflow: write_pointer=2, corrupt read_pointer=5 gives fill 5 > 4
    cyc(1'b1, 3'd0, 1'b1, 2'd0);
    cyc(1'b1, 3'd0, 1'b1, 2'd1);
    chk("ovf_pre_write_pointer", int'(write_pointer), 2);
    cyc(1'b0, 3'd5, 1'b0, 2'd2);
    chk("ovf_flag", int'(overflow_error), 1);
    chk("ovf_ready", int'(write_ready), 0);
    chk("ovf_fill_level", int'(fill_level), 5);
    cyc(1'b1, 3'd2, 1'b0, 2'd2);
    chk("ovf_sticky", int'(overflow_error), 1);
    chk("ovf_sticky_ready", int'(write_ready), 0);
    chk("ovf_fill_updates", int'(fill_level), 0);
    chk("ovf_pointer_frozen", int'(write_pointer), 2);

    // reset clears the sticky flag
    write_valid = 1'b0; read_pointer = '0;
    rst_n = 1'b0; #1;
    chk("ovf_reset_clear", int'(overflow_error), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // mid-cycle asynchronous reset with write_pointer=3
    cyc(1'b1, 3'd0, 1'b1, 2'd0);
    cyc(1'b1, 3'd0, 1'b1, 2'd1);
    cyc(1'b1, 3'd0, 1'b1, 2'd2);
    chk("arst_pre_write_pointer", int'(write_pointer), 3);
    write_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_write_pointer", int'(write_pointer), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_fill_level", int'(fill_level), 0);
    chk("arst_ready", int'(write_ready), 1);
    chk("arst_enable", int'(write_enable), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
